// File: rtl/apex7_po_fifo.sv
// Capture FIFO for the apex7 primary-output word with a registered head and a saturating drop counter.
// Optional build macro APEX7_PO_PARITY_EN adds a stored even-parity bit as out_po[PO_W].
module apex7_po_fifo #(
  parameter int PO_W  = 37,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PO_W-1:0]  in_po,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef APEX7_PO_PARITY_EN
  output logic [PO_W:0]    out_po,
`else
  output logic [PO_W-1:0]  out_po,
`endif
  output logic [AW:0]      level,
  output logic [CNT_W-1:0] drop_cnt
);

`ifdef APEX7_PO_PARITY_EN
  localparam int MW = PO_W + 1;
`else
  localparam int MW = PO_W;
`endif
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wdata;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   level_nxt, remain;
  logic          push, pop, head_vld, drop;

`ifdef APEX7_PO_PARITY_EN
  assign wdata = {^in_po, in_po};
`else
  assign wdata = in_po;
`endif

  // A flush discards both sides of the handshake for this cycle.
  assign push       = in_valid & in_ready & ~clr;
  assign pop        = out_valid & out_ready & ~clr;
  assign drop       = in_valid & ~in_ready & ~clr;
  assign level_nxt  = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign rd_ptr_nxt = rd_ptr + {{(AW-1){1'b0}}, pop};
  // Only entries already stored before this edge may become the head, so a
  // word written this edge is never read back on the same edge.
  assign remain     = level - {{AW{1'b0}}, pop};
  assign head_vld   = (remain != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_po    <= '0;
      drop_cnt  <= '0;
    end else begin
      if (drop) drop_cnt <= sat_inc(drop_cnt);
      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        wr_ptr    <= wr_ptr + {{(AW-1){1'b0}}, push};
        rd_ptr    <= rd_ptr_nxt;
        level     <= level_nxt;
        in_ready  <= (level_nxt != FULL_LVL);
        out_valid <= head_vld;
        if (head_vld) out_po <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: tb/tb_apex7_po_fifo.sv
// Directed bench for apex7_po_fifo: reset, latency, fill/overflow, streaming, flush, saturation, parity.
module tb_apex7_po_fifo;
  localparam int PO_W = 37, DEPTH = 4, AW = 2, CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, clr, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [PO_W-1:0]  in_po;
`ifdef APEX7_PO_PARITY_EN
  logic [PO_W:0]    out_po;
`else
  logic [PO_W-1:0]  out_po;
`endif
  logic [AW:0]      level;
  logic [CNT_W-1:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  apex7_po_fifo #(.PO_W(PO_W), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_po(in_po), .out_valid(out_valid), .out_ready(out_ready), .out_po(out_po),
    .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_po = '0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_eq("rel_in_ready", 64'(in_ready), 64'd1);

    // single word into an empty FIFO
    in_valid = 1'b1; in_po = 37'h0_0000_1ABC;
    tick();
    in_valid = 1'b0;
    check_eq("single_lat_valid", 64'(out_valid), 64'd0);
    check_eq("single_level", 64'(level), 64'd1);
    tick();
    check_eq("single_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("single_hold%0d", i), 64'(out_po[PO_W-1:0]), 64'h1ABC);
      tick();
    end
    check_eq("single_still_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("single_pop_valid", 64'(out_valid), 64'd0);
    check_eq("single_pop_level", 64'(level), 64'd0);

    // fill and overflow: words 5 and 6 are refused
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_po = PO_W'(i);
      tick();
    end
    in_valid = 1'b0;
    check_eq("fill_level", 64'(level), 64'd4);
    check_eq("fill_in_ready", 64'(in_ready), 64'd0);
    check_eq("fill_drop", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("drain_valid%0d", k), 64'(out_valid), 64'd1);
      check_eq($sformatf("drain_po%0d", k), 64'(out_po[PO_W-1:0]), 64'(k));
      tick();
    end
    out_ready = 1'b0;
    check_eq("drain_level", 64'(level), 64'd0);
    check_eq("drain_valid_end", 64'(out_valid), 64'd0);
    check_eq("drain_in_ready", 64'(in_ready), 64'd1);

    // simultaneous push/pop at level 2 across pointer wrap
    in_valid = 1'b1; in_po = 37'd10; tick();
    in_po = 37'd11; tick();
    in_valid = 1'b0; tick();
    check_eq("sim_start_level", 64'(level), 64'd2);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_po = PO_W'(12 + i);
      check_eq($sformatf("sim_valid%0d", i), 64'(out_valid), 64'd1);
      check_eq($sformatf("sim_po%0d", i), 64'(out_po[PO_W-1:0]), 64'(10 + i));
      tick();
      check_eq($sformatf("sim_level%0d", i), 64'(level), 64'd2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("sim_head_after", 64'(out_po[PO_W-1:0]), 64'd20);

    // flush at level 3 with both handshakes requested
    in_valid = 1'b1; in_po = 37'd22; tick();
    in_valid = 1'b0;
    check_eq("flush_pre_level", 64'(level), 64'd3);
    clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_po = 37'd99;
    tick();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("flush_level", 64'(level), 64'd0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    check_eq("flush_drop", 64'(drop_cnt), 64'd2);
    tick();
    check_eq("flush_no_late_word", 64'(level), 64'd0);
    check_eq("flush_no_late_valid", 64'(out_valid), 64'd0);

    // flush while full: the refused push is not a drop
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_po = PO_W'(40 + i);
      tick();
    end
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check_eq("full_flush_drop", 64'(drop_cnt), 64'd2);
    check_eq("full_flush_level", 64'(level), 64'd0);

    // drop counter saturation
    in_valid = 1'b1;
    for (int i = 0; i < 4 + 260; i++) begin
      in_po = PO_W'(i);
      tick();
    end
    in_valid = 1'b0;
    check_eq("sat_drop", 64'(drop_cnt), 64'd255);
    check_eq("sat_level", 64'(level), 64'd4);
    tick();
    check_eq("sat_head", 64'(out_po[PO_W-1:0]), 64'd0);

    // asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_level", 64'(level), 64'd0);
    check_eq("mid_rst_drop", 64'(drop_cnt), 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("mid_rst_po", 64'(out_po), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mid_rel_in_ready", 64'(in_ready), 64'd1);
    check_eq("mid_rel_valid", 64'(out_valid), 64'd0);

`ifdef APEX7_PO_PARITY_EN
    in_valid = 1'b1; in_po = 37'h1F_FFFF_FFFF; tick();
    in_valid = 1'b0; tick();
    check_eq("par_ones_bit", 64'(out_po[PO_W]), 64'd1);
    check_eq("par_ones_word", 64'(out_po[PO_W-1:0]), 64'h1F_FFFF_FFFF);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_po = '0; tick();
    in_valid = 1'b0; tick();
    check_eq("par_zero_valid", 64'(out_valid), 64'd1);
    check_eq("par_zero_bit", 64'(out_po[PO_W]), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
